// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the oldest-first arbiter and its max-finder tree.
//   - arb_state_e : grant FSM states (ARB_IDLE / ARB_GRANT)
//   - AGE_MAX()   : saturation value of an age counter of a given width
//   - arb_leaf_t  : packed finder-tree node {pending, age, idx}. Its layout
//                   matches the tree output for the default widths below.
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_AGE_SZ = 4;
  localparam int ARB_IDX_SZ = 3;

  typedef struct packed {
    logic                  pending;
    logic [ARB_AGE_SZ-1:0] age;
    logic [ARB_IDX_SZ-1:0] idx;
  } arb_leaf_t;

  function automatic int unsigned AGE_MAX(input int unsigned age_sz);
    return (32'd1 << age_sz) - 32'd1;
  endfunction

endpackage

// File: rtl/age_max_tree.sv
// -----------------------------------------------------------------------------
// age_max_tree
// Purely combinational binary max-finder. Each leaf is {pending, age, idx};
// a node keeps left when left.key >= right.key, so ties resolve to the lower
// index. Non-pending leaves have their age forced to zero, so they always
// lose against any pending leaf.
// Ports:
//   i_pending  in  LEAF_NUM         per-leaf pending flag
//   i_age      in  LEAF_NUM*AGE_SZ  per-leaf age, leaf i at [i*AGE_SZ +: AGE_SZ]
//   o_win      out NODE_W           winning node {pending, age, idx}
// -----------------------------------------------------------------------------
module age_max_tree #(
  parameter  int LEVEL    = 4,
  parameter  int AGE_SZ   = 4,
  localparam int LEAF_NUM = 1 << (LEVEL - 1),
  localparam int IDX_SZ   = LEVEL - 1,
  localparam int NODE_W   = 1 + AGE_SZ + IDX_SZ
) (
  input  logic [LEAF_NUM-1:0]        i_pending,
  input  logic [LEAF_NUM*AGE_SZ-1:0] i_age,
  output logic [NODE_W-1:0]          o_win
);

  genvar gl, gi;

  // Level 0 holds the leaves, level LEVEL-1 holds the single root node.
  // Each level has its own array so no array feeds back into itself.
  for (gl = 0; gl < LEVEL; gl++) begin : g_lvl
    localparam int NN = 1 << (LEVEL - 1 - gl);
    logic [NODE_W-1:0] w_node [NN];

    for (gi = 0; gi < NN; gi++) begin : g_n
      if (gl == 0) begin : g_leaf
        assign w_node[gi] = {i_pending[gi],
                             {AGE_SZ{i_pending[gi]}} & i_age[gi*AGE_SZ +: AGE_SZ],
                             IDX_SZ'(gi)};
      end else begin : g_cmp
        logic [NODE_W-1:0] w_left;
        logic [NODE_W-1:0] w_right;
        assign w_left  = g_lvl[gl-1].w_node[2*gi];
        assign w_right = g_lvl[gl-1].w_node[2*gi+1];
        // Compare only the key {pending, age}; >= keeps the lower index on ties.
        assign w_node[gi] = (w_left[NODE_W-1:IDX_SZ] >= w_right[NODE_W-1:IDX_SZ])
                            ? w_left : w_right;
      end
    end
  end

  assign o_win = g_lvl[LEVEL-1].w_node[0];

endmodule

// File: rtl/oldest_first_arbiter.sv
// -----------------------------------------------------------------------------
// oldest_first_arbiter
// Shares one downstream port among REQ_NUM requesters, always granting the
// pending request with the largest saturating wait age (lowest index on ties).
// Optional feature macro: ARB_PERF_CNT_EN adds grant_cnt / sat_cnt outputs.
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   per-slot request, level-held until accepted
//   req_ready  out  per-slot accept (= ~pending)
//   req_done   out  one-cycle pulse when a slot's grant completes
//   gnt_valid  out  grant available downstream
//   gnt_idx    out  granted slot, stable while gnt_valid && !gnt_ready
//   gnt_age    out  age of the granted slot as it stands once granted
//   gnt_ready  in   downstream accepts the grant
//   grant_cnt  out  (ARB_PERF_CNT_EN) completed handshakes, wraps
//   sat_cnt    out  (ARB_PERF_CNT_EN) grants issued with a saturated age
// -----------------------------------------------------------------------------
module oldest_first_arbiter
  import arb_pkg::*;
#(
  parameter int REQ_NUM = 8,
  parameter int LEVEL   = 4,
  parameter int AGE_SZ  = 4,
  parameter int IDX_SZ  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req_valid,
  output logic [REQ_NUM-1:0] req_ready,
  output logic [REQ_NUM-1:0] req_done,
  output logic               gnt_valid,
  output logic [IDX_SZ-1:0]  gnt_idx,
  output logic [AGE_SZ-1:0]  gnt_age,
  input  logic               gnt_ready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        grant_cnt,
  output logic [31:0]        sat_cnt
`endif
);

  localparam logic [AGE_SZ-1:0] AGE_TOP = AGE_SZ'(AGE_MAX(AGE_SZ));

  arb_state_e                r_state;
  arb_state_e                w_state_next;
  logic [REQ_NUM-1:0]        r_pending;
  logic [REQ_NUM-1:0]        r_done;
  logic [AGE_SZ-1:0]         r_age [REQ_NUM];
  logic [IDX_SZ-1:0]         r_gnt_idx;
  logic [AGE_SZ-1:0]         r_gnt_age;

  logic [REQ_NUM-1:0]        w_granted;
  logic [REQ_NUM-1:0]        w_leaf_pending;
  logic [REQ_NUM-1:0]        w_accept;
  logic [REQ_NUM-1:0]        w_pending_next;
  logic [REQ_NUM-1:0]        w_done_next;
  logic [AGE_SZ-1:0]         w_age_next [REQ_NUM];
  logic [REQ_NUM*AGE_SZ-1:0] w_age_flat;
  arb_leaf_t                 w_win;
  logic [AGE_SZ-1:0]         w_win_age_inc;
  logic                      w_handshake;
  logic                      w_load;

  assign w_handshake = (r_state == ARB_GRANT) && gnt_ready;

  genvar gi;
  for (gi = 0; gi < REQ_NUM; gi++) begin : g_slot
    assign w_granted[gi]      = (r_state == ARB_GRANT) && (r_gnt_idx == IDX_SZ'(gi));
    // The granted slot is masked out of the tree, so on a handshake the tree
    // already yields the next winner; the mask also freezes its age.
    assign w_leaf_pending[gi] = r_pending[gi] && !w_granted[gi];
    assign w_accept[gi]       = req_valid[gi] && !r_pending[gi];
    assign w_done_next[gi]    = w_handshake && w_granted[gi];
    assign w_pending_next[gi] = w_done_next[gi] ? 1'b0 : (r_pending[gi] || req_valid[gi]);
    assign w_age_next[gi]     = w_accept[gi] ? '0 :
                                (w_leaf_pending[gi] && (r_age[gi] != AGE_TOP))
                                ? r_age[gi] + 1'b1 : r_age[gi];
    assign w_age_flat[gi*AGE_SZ +: AGE_SZ] = r_age[gi];
  end

  age_max_tree #(
    .LEVEL  (LEVEL),
    .AGE_SZ (AGE_SZ)
  ) u_tree (
    .i_pending (w_leaf_pending),
    .i_age     (w_age_flat),
    .o_win     (w_win)
  );

  // The winner is not granted in the selection cycle, so its age still
  // advances on the loading edge; gnt_age captures that post-edge value and
  // thereafter equals the (frozen) age register of the granted slot.
  assign w_win_age_inc = (w_win.age == AGE_TOP) ? AGE_TOP : w_win.age + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_win.pending) begin
          w_load       = 1'b1;
          w_state_next = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (gnt_ready) begin
          if (w_win.pending) begin
            w_load = 1'b1;
          end else begin
            w_state_next = ARB_IDLE;
          end
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_done    <= '0;
      r_gnt_idx <= '0;
      r_gnt_age <= '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      r_pending <= w_pending_next;
      r_done    <= w_done_next;
      for (int i = 0; i < REQ_NUM; i++) begin
        r_age[i] <= w_age_next[i];
      end
      if (w_load) begin
        r_gnt_idx <= w_win.idx;
        r_gnt_age <= w_win_age_inc;
      end
    end
  end

  assign req_ready = ~r_pending;
  assign req_done  = r_done;
  assign gnt_valid = (r_state == ARB_GRANT);
  assign gnt_idx   = r_gnt_idx;
  assign gnt_age   = r_gnt_age;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_grant_cnt;
  logic [31:0] r_sat_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
      r_sat_cnt   <= '0;
    end else begin
      if (w_handshake) begin
        r_grant_cnt <= r_grant_cnt + 32'd1;
      end
      if (w_load && (w_win_age_inc == AGE_TOP)) begin
        r_sat_cnt <= r_sat_cnt + 32'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign sat_cnt   = r_sat_cnt;
`endif

endmodule

// File: tb/tb_oldest_first_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oldest_first_arbiter
// Scoreboard bench: each scenario pushes the grants it expects ({idx, age})
// when it drives requests; a negedge monitor pops one entry per handshake and
// also checks the req_done pulse that must follow every handshake.
// -----------------------------------------------------------------------------
module tb_oldest_first_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_valid;
  logic [7:0] req_ready;
  logic [7:0] req_done;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [3:0] gnt_age;
  logic       gnt_ready;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] grant_cnt;
  logic [31:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  oldest_first_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_done  (req_done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_age   (gnt_age),
    .gnt_ready (gnt_ready)
`ifdef ARB_PERF_CNT_EN
    ,
    .grant_cnt (grant_cnt),
    .sat_cnt   (sat_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] age;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         hs_cnt    = 0;
  int         sat_seen  = 0;
  logic [7:0] exp_done  = 8'h00;
  int         tie_order [3] = '{1, 3, 6};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int age);
    exp_t e;
    e.idx = 3'(idx);
    e.age = 4'(age);
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || gnt_valid) && k < 60) begin
      cyc(1);
      k++;
    end
    check({tag, "_left"}, sb_q.size(), 0);
    check({tag, "_idle"}, gnt_valid, 0);
  endtask

  // Monitor: a handshake seen here completes on the next rising edge, so the
  // matching req_done pulse is checked on the following negedge.
  always @(negedge clk) begin
    check("req_done", req_done, exp_done);
    if (rst_n && gnt_valid && gnt_ready) begin
      check("sb_depth", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        $display("grant idx=%0d age=%0d (expect idx=%0d age=%0d)",
                 gnt_idx, gnt_age, mon_e.idx, mon_e.age);
        check("gnt_idx", gnt_idx, mon_e.idx);
        check("gnt_age", gnt_age, mon_e.age);
        if (mon_e.age == 4'hF) sat_seen++;
      end
      hs_cnt++;
      exp_done = 8'd1 << gnt_idx;
    end else begin
      exp_done = 8'h00;
    end
    if (!rst_n) begin
      hs_cnt   = 0;
      sat_seen = 0;
    end
  end

  initial begin
    // Reset held with every slot requesting.
    rst_n     = 1'b0;
    req_valid = 8'hFF;
    gnt_ready = 1'b0;
    cyc(3);
    check("rst_gnt_valid", gnt_valid, 0);
    check("rst_req_ready", req_ready, 8'hFF);
    check("rst_req_done", req_done, 0);
    rst_n = 1'b1;
    cyc(1);
    req_valid = 8'h00;
    check("accept_no_gnt", gnt_valid, 0);
    check("accept_ready", req_ready, 8'h00);
    cyc(1);
    check("first_gnt_valid", gnt_valid, 1);
    check("first_gnt_idx", gnt_idx, 0);
    check("first_gnt_age", gnt_age, 1);
    // All accepted together: slot k is granted k cycles later at age k+1.
    for (int k = 0; k < 8; k++) push(k, k + 1);
    gnt_ready = 1'b1;
    drain("t1");

    // Age order: slot 5 first, slot 2 three cycles later, stalled.
    gnt_ready = 1'b0;
    req_valid = 8'h20;
    cyc(1);
    req_valid = 8'h00;
    cyc(2);
    req_valid = 8'h04;
    cyc(1);
    req_valid = 8'h00;
    cyc(3);
    check("age_hold_idx", gnt_idx, 5);
    check("age_hold_age", gnt_age, 1);
    push(5, 1);
    push(2, 4);
    gnt_ready = 1'b1;
    drain("t2");

    // Tie-break: equal ages resolve to the lowest index, one grant per cycle.
    req_valid = 8'h4A;
    push(1, 1);
    push(3, 2);
    push(6, 3);
    cyc(1);
    req_valid = 8'h00;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("tie_valid", gnt_valid, 1);
      check("tie_idx", gnt_idx, tie_order[k]);
    end
    cyc(1);
    check("tie_idle", gnt_valid, 0);
    check("tie_left", sb_q.size(), 0);

    // Saturation: slot 7 waits 20+ cycles behind a stalled grant on slot 0.
    gnt_ready = 1'b0;
    req_valid = 8'h01;
    cyc(1);
    req_valid = 8'h80;
    cyc(1);
    req_valid = 8'h00;
    cyc(20);
    check("sat_hold_idx", gnt_idx, 0);
    push(0, 1);
    push(7, 15);
    gnt_ready = 1'b1;
    drain("t4");
`ifdef ARB_PERF_CNT_EN
    check("grant_cnt", grant_cnt, hs_cnt);
    check("sat_cnt", sat_cnt, sat_seen);
`endif

    // Stall stability: new requests arrive while slot 4 is held.
    gnt_ready = 1'b0;
    req_valid = 8'h10;
    cyc(1);
    req_valid = 8'h00;
    cyc(1);
    check("stall_first_idx", gnt_idx, 4);
    req_valid = 8'h91;
    cyc(1);
    req_valid = 8'h00;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("stall_valid", gnt_valid, 1);
      check("stall_idx", gnt_idx, 4);
      check("stall_age", gnt_age, 1);
      check("stall_ready", req_ready, 8'h6E);
    end
    push(4, 1);
    push(0, 11);
    push(7, 12);
    gnt_ready = 1'b1;
    drain("t5");

    // Reset in the middle of a grant.
    gnt_ready = 1'b0;
    req_valid = 8'h06;
    cyc(1);
    req_valid = 8'h00;
    cyc(1);
    check("mid_gnt_valid", gnt_valid, 1);
    check("mid_gnt_idx", gnt_idx, 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("mid_rst_valid", gnt_valid, 0);
    check("mid_rst_ready", req_ready, 8'hFF);
    gnt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("mid_no_gnt", gnt_valid, 0);
    end
`ifdef ARB_PERF_CNT_EN
    check("mid_grant_cnt", grant_cnt, hs_cnt);
`endif
    req_valid = 8'h04;
    push(2, 1);
    cyc(1);
    req_valid = 8'h00;
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/oldest_first_arbiter.md
# oldest_first_arbiter

Age-based arbiter that shares one downstream resource port among REQ_NUM requesters, always granting the longest-waiting pending request. Each requester slot keeps a saturating wait-age counter. A max-value finder tree, the same binary-tree extremum structure the team uses for min/max finding, picks the winner. The block sits in front of any shared unit (issue port, memory port, bus master) that needs starvation-free, fair-by-age scheduling.

## Interface
- REQ_NUM, 8: number of requesters; must be a power of two (2^(LEVEL-1)).
- LEVEL, 4: finder tree depth; REQ_NUM = 1<<(LEVEL-1).
- AGE_SZ, 4: width of each age counter.
- IDX_SZ, 3: width of the grant index; equals LEVEL-1.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  REQ_NUM  per-slot request, level-held until accepted.
- req_ready  out  REQ_NUM  per-slot accept; equals ~pending[i], registered.
- req_done  out  REQ_NUM  one-cycle pulse on slot i when its grant completes.
- gnt_valid  out  1  grant available to the downstream resource.
- gnt_idx  out  IDX_SZ  index of the granted slot; stable while gnt_valid && !gnt_ready.
- gnt_age  out  AGE_SZ  age of the granted slot at selection, for debug and QoS.
- gnt_ready  in  1  downstream accepts the grant.

## Operation
- Slot state: pending[i] (1 bit) and age[i] (AGE_SZ bits).
- Accept: req_valid[i] && req_ready[i] sets pending[i]=1 and age[i]=0 on the next edge.
- Aging: every cycle, each pending slot not currently granted increments age[i], saturating at 2^AGE_SZ-1. The granted slot's age is frozen.
- Selection is combinational from registered state:
  - Tree leaves are {pending[i], age[i]}. Non-pending leaves compare as lowest.
  - Node rule is left >= right ? left : right. Leaf i sits at position i, so ties go to the lower index.
  - The tree carries the winner's index alongside its key.
- FSM states:
  - IDLE: gnt_valid=0. If any slot is pending, register the winner into gnt_idx and gnt_age, set gnt_valid=1, and move to GRANT.
  - GRANT: hold gnt_idx and gnt_age while !gnt_ready. On gnt_valid && gnt_ready:
    - clear pending[gnt_idx] and pulse req_done[gnt_idx] on the next cycle;
    - recompute the winner with the granted slot masked;
    - if another slot is pending, load it (stay in GRANT, back-to-back); otherwise go to IDLE with gnt_valid=0.
- A newly accepted request cannot win in the cycle it is accepted; pending only becomes visible on the next edge.
- A cleared slot shows req_ready=1 in the cycle after completion and may be re-accepted then.
- A slot whose req_valid drops while pending stays pending; requests cannot be withdrawn.

## Timing
- Reset (rst_n=0 at an edge) clears pending, age, gnt_valid, gnt_idx, gnt_age and req_done, and sets req_ready to all-ones. Reset mid-grant drops the grant with no req_done.
- Latency, request to grant: req_valid accepted at edge T, pending visible after T, gnt_valid asserted after edge T+1 (2 cycles).
- Grant to done: handshake at edge H, then req_done pulse and pending clear both visible after H.
- Back-to-back throughput: one grant per cycle while any slot is pending.
- Saturated ages tie; the lowest index among them wins.

## Configuration
- ARB_PERF_CNT_EN: when defined, adds two outputs:
  - grant_cnt (32b): counts completed handshakes, wraps modulo 2^32.
  - sat_cnt (32b): counts grants issued with gnt_age == 2^AGE_SZ-1.
  - Both reset to 0.
- When undefined, neither port nor its counters exists; all other behaviour is identical.

## Structure
- Shared package arb_pkg holds:
  - the ARB_IDLE/ARB_GRANT state enum;
  - the AGE_MAX constant function of AGE_SZ;
  - the packed leaf typedef {pending, age, idx}.
- One sub-module, age_max_tree: a parameterised by LEVEL/AGE_SZ, purely combinational binary tree that returns the winning key and index, ties to the left. The arbiter FSM, counters and handshake stay in oldest_first_arbiter.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req_valid=8'hFF. Require gnt_valid=0, req_ready=8'hFF, req_done=0; after release, first grant gnt_idx=0 at +2 cycles.
- Age order: accept slot 5 at cycle 0 and slot 2 at cycle 3, gnt_ready=0 until cycle 6. Require gnt_idx=5 first with gnt_age=1, then gnt_idx=2, then req_done pulses 8'h20 then 8'h04.
- Tie-break: accept slots 3, 6 and 1 in the same cycle, gnt_ready=1. Require grants in order 1, 3, 6 on consecutive cycles, then gnt_valid=0.
- Saturation: AGE_SZ=4; accept slot 7, hold a grant on slot 0 stalled 20 cycles. Require age[7]=15 (not wrapped) and gnt_age=15 when slot 7 is granted.
- Stall stability: gnt_ready=0 for 10 cycles while new requests arrive. Require gnt_idx and gnt_age constant and the granted slot's age frozen.
- Mid-grant reset: assert rst_n=0 during GRANT. Require no req_done, all pending cleared, next grant only after re-request; with ARB_PERF_CNT_EN, grant_cnt=0.
